// File: rtl/rf_sched_pkg.sv
// Shared widths, the FIFO entry layout and the one-hot decoder used by the
// register-file write-port scheduler.
package rf_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef struct packed {
        logic                  live;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } rf_entry_t;

    function automatic logic [31:0] onehot32(input logic [4:0] addr);
        onehot32 = 32'd1 << addr;
    endfunction

endpackage

// File: rtl/rf_sched_fifo.sv
// Small in-order queue of long-latency results. Entries carry a live bit that
// writeback can clear by address match, so stale results drain without writing.
module rf_sched_fifo
    import rf_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           push_live,
    input  logic [ADDR_W-1:0]              push_addr,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    input  logic                           kill_valid,
    input  logic [ADDR_W-1:0]              kill_addr,
    output logic                           head_live,
    output logic [ADDR_W-1:0]              head_addr,
    output logic [DATA_W-1:0]              head_data,
    output logic                           full,
    output logic                           empty,
    output logic [DEPTH-1:0]               live_vec,
    output logic [DEPTH-1:0][ADDR_W-1:0]   addr_vec
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]             live_q, live_d;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;

    // Live bits are cleared on pop, so only occupied slots can ever be live.
    always_comb begin
        live_d   = live_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_valid && addr_q[i] == kill_addr) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            live_d[wr_ptr_q] = push_live;
            addr_d[wr_ptr_q] = push_addr;
            data_d[wr_ptr_q] = push_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q   <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            live_q   <= live_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_live = live_q[rd_ptr_q];
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign live_vec  = live_q;
    assign addr_vec  = addr_q;

endmodule

// File: rtl/rf_write_sched.sv
// Shares the register file's single write port between writeback (always wins)
// and queued long-latency results, and reports which registers are pending.
module rf_write_sched
    import rf_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              CLOCK,
    input  logic              RESETN,
    input  logic              WB_VALID,
    input  logic [ADDR_W-1:0] WB_ADDR,
    input  logic [DATA_W-1:0] WB_DATA,
    input  logic              LU_VALID,
    output logic              LU_READY,
    input  logic [ADDR_W-1:0] LU_ADDR,
    input  logic [DATA_W-1:0] LU_DATA,
    output logic              RF_WE,
    output logic [ADDR_W-1:0] RF_A3,
    output logic [DATA_W-1:0] RF_WD3,
    output logic [31:0]       PEND_MASK,
    output logic [15:0]       DEFER_CNT
);

    logic                         wb_win;
    logic                         fifo_pop, fifo_push, push_live;
    logic                         head_live, fifo_full, fifo_empty;
    logic [ADDR_W-1:0]            head_addr;
    logic [DATA_W-1:0]            head_data;
    logic [DEPTH-1:0]             live_vec;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_vec;

    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
    logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d;
    logic [15:0]       defer_q, defer_d;

    // A write to r0 is treated as no write at all, freeing the port for the FIFO.
    assign wb_win    = WB_VALID && (WB_ADDR != '0);
    assign LU_READY  = RESETN && !fifo_full;
    assign fifo_push = LU_VALID && LU_READY && (LU_ADDR != '0);
    assign push_live = !(wb_win && (WB_ADDR == LU_ADDR));
    assign fifo_pop  = !wb_win && !fifo_empty;

    rf_sched_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (CLOCK),
        .rst_n      (RESETN),
        .push       (fifo_push),
        .push_live  (push_live),
        .push_addr  (LU_ADDR),
        .push_data  (LU_DATA),
        .pop        (fifo_pop),
        .kill_valid (wb_win),
        .kill_addr  (WB_ADDR),
        .head_live  (head_live),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .live_vec   (live_vec),
        .addr_vec   (addr_vec)
    );

    always_comb begin
        rf_we_d  = 1'b0;
        rf_a3_d  = rf_a3_q;
        rf_wd3_d = rf_wd3_q;
        defer_d  = defer_q;
        if (wb_win) begin
            rf_we_d  = 1'b1;
            rf_a3_d  = WB_ADDR;
            rf_wd3_d = WB_DATA;
            if (head_live && defer_q != 16'hFFFF) begin
                defer_d = defer_q + 16'd1;
            end
        end else if (fifo_pop && head_live) begin
            rf_we_d  = 1'b1;
            rf_a3_d  = head_addr;
            rf_wd3_d = head_data;
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            rf_we_q  <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd3_q <= '0;
            defer_q  <= '0;
        end else begin
            rf_we_q  <= rf_we_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd3_q <= rf_wd3_d;
            defer_q  <= defer_d;
        end
    end

    always_comb begin
        PEND_MASK = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_vec[i]) begin
                PEND_MASK = PEND_MASK | onehot32(5'(addr_vec[i]));
            end
        end
        if (rf_we_q) begin
            PEND_MASK = PEND_MASK | onehot32(5'(rf_a3_q));
        end
        PEND_MASK[0] = 1'b0;
    end

    assign RF_WE     = rf_we_q;
    assign RF_A3     = rf_a3_q;
    assign RF_WD3    = rf_wd3_q;
    assign DEFER_CNT = defer_q;

endmodule

// File: tb/tb_rf_write_sched.sv
// Directed scenarios for the register-file write-port scheduler with
// hand-computed expectations checked after each rising edge.
module tb_rf_write_sched;

    logic        CLOCK;
    logic        RESETN;
    logic        WB_VALID;
    logic [4:0]  WB_ADDR;
    logic [31:0] WB_DATA;
    logic        LU_VALID;
    logic        LU_READY;
    logic [4:0]  LU_ADDR;
    logic [31:0] LU_DATA;
    logic        RF_WE;
    logic [4:0]  RF_A3;
    logic [31:0] RF_WD3;
    logic [31:0] PEND_MASK;
    logic [15:0] DEFER_CNT;

    int total = 0;
    int bad   = 0;

    rf_write_sched #(
        .DATA_W (32),
        .ADDR_W (5),
        .DEPTH  (2)
    ) dut (
        .CLOCK     (CLOCK),
        .RESETN    (RESETN),
        .WB_VALID  (WB_VALID),
        .WB_ADDR   (WB_ADDR),
        .WB_DATA   (WB_DATA),
        .LU_VALID  (LU_VALID),
        .LU_READY  (LU_READY),
        .LU_ADDR   (LU_ADDR),
        .LU_DATA   (LU_DATA),
        .RF_WE     (RF_WE),
        .RF_A3     (RF_A3),
        .RF_WD3    (RF_WD3),
        .PEND_MASK (PEND_MASK),
        .DEFER_CNT (DEFER_CNT)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic drive_idle();
        WB_VALID = 1'b0; WB_ADDR = '0; WB_DATA = '0;
        LU_VALID = 1'b0; LU_ADDR = '0; LU_DATA = '0;
    endtask

    task automatic test_reset();
        RESETN = 1'b0;
        drive_idle();
        #2;
        total++; if (RF_WE !== 1'b0) begin bad++; $display("[TB] FAIL rst_we got=%0h want=0", RF_WE); end
        total++; if (RF_A3 !== 5'd0) begin bad++; $display("[TB] FAIL rst_a3 got=%0h want=0", RF_A3); end
        total++; if (RF_WD3 !== 32'd0) begin bad++; $display("[TB] FAIL rst_wd3 got=%0h want=0", RF_WD3); end
        total++; if (PEND_MASK !== 32'd0) begin bad++; $display("[TB] FAIL rst_pend got=%0h want=0", PEND_MASK); end
        total++; if (DEFER_CNT !== 16'd0) begin bad++; $display("[TB] FAIL rst_defer got=%0h want=0", DEFER_CNT); end
        total++; if (LU_READY !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready got=%0h want=0", LU_READY); end
        tick();
        RESETN = 1'b1;
        #1;
        total++; if (LU_READY !== 1'b1) begin bad++; $display("[TB] FAIL rel_ready got=%0h want=1", LU_READY); end
    endtask

    task automatic test_wb_only();
        WB_VALID = 1'b1; WB_ADDR = 5'd5; WB_DATA = 32'hDEADBEEF;
        tick();
        WB_VALID = 1'b0;
        total++; if (RF_WE !== 1'b1) begin bad++; $display("[TB] FAIL wb_we got=%0h want=1", RF_WE); end
        total++; if (RF_A3 !== 5'd5) begin bad++; $display("[TB] FAIL wb_a3 got=%0h want=5", RF_A3); end
        total++; if (RF_WD3 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wb_wd3 got=%0h want=deadbeef", RF_WD3); end
        total++; if (PEND_MASK !== 32'h20) begin bad++; $display("[TB] FAIL wb_pend got=%0h want=20", PEND_MASK); end
        tick();
        total++; if (RF_WE !== 1'b0) begin bad++; $display("[TB] FAIL wb_we_off got=%0h want=0", RF_WE); end
        total++; if (PEND_MASK !== 32'h0) begin bad++; $display("[TB] FAIL wb_pend_off got=%0h want=0", PEND_MASK); end
        total++; if (RF_WD3 !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL wb_wd3_hold got=%0h want=deadbeef", RF_WD3); end
    endtask

    task automatic test_contention();
        LU_VALID = 1'b1; LU_ADDR = 5'd7; LU_DATA = 32'h11;
        tick();
        LU_VALID = 1'b0;
        total++; if (PEND_MASK !== 32'h80) begin bad++; $display("[TB] FAIL cont_pend_q got=%0h want=80", PEND_MASK); end
        WB_VALID = 1'b1; WB_ADDR = 5'd3; WB_DATA = 32'h33;
        tick();
        total++; if (PEND_MASK !== 32'h88) begin bad++; $display("[TB] FAIL cont_pend_wb got=%0h want=88", PEND_MASK); end
        WB_DATA = 32'h34;
        tick();
        WB_VALID = 1'b0;
        total++; if (RF_WD3 !== 32'h34) begin bad++; $display("[TB] FAIL cont_wb2 got=%0h want=34", RF_WD3); end
        tick();
        total++; if (RF_WE !== 1'b1) begin bad++; $display("[TB] FAIL cont_we got=%0h want=1", RF_WE); end
        total++; if (RF_A3 !== 5'd7) begin bad++; $display("[TB] FAIL cont_a3 got=%0h want=7", RF_A3); end
        total++; if (RF_WD3 !== 32'h11) begin bad++; $display("[TB] FAIL cont_wd3 got=%0h want=11", RF_WD3); end
        total++; if (DEFER_CNT !== 16'd2) begin bad++; $display("[TB] FAIL cont_defer got=%0d want=2", DEFER_CNT); end
        tick();
        total++; if (PEND_MASK !== 32'h0) begin bad++; $display("[TB] FAIL cont_pend_end got=%0h want=0", PEND_MASK); end
    endtask

    task automatic test_full();
        WB_VALID = 1'b1; WB_ADDR = 5'd1; WB_DATA = 32'h1;
        LU_VALID = 1'b1; LU_ADDR = 5'd10; LU_DATA = 32'hA0;
        tick();
        total++; if (LU_READY !== 1'b1) begin bad++; $display("[TB] FAIL full_ready1 got=%0h want=1", LU_READY); end
        LU_ADDR = 5'd11; LU_DATA = 32'hB0;
        tick();
        total++; if (LU_READY !== 1'b0) begin bad++; $display("[TB] FAIL full_ready2 got=%0h want=0", LU_READY); end
        LU_ADDR = 5'd12; LU_DATA = 32'hC0;
        tick();
        total++; if (LU_READY !== 1'b0) begin bad++; $display("[TB] FAIL full_held got=%0h want=0", LU_READY); end
        total++; if (PEND_MASK !== 32'h0C02) begin bad++; $display("[TB] FAIL full_pend got=%0h want=c02", PEND_MASK); end
        WB_VALID = 1'b0;
        tick();
        total++; if (RF_A3 !== 5'd10 || RF_WD3 !== 32'hA0) begin bad++; $display("[TB] FAIL full_pop1 got=%0h/%0h want=a/a0", RF_A3, RF_WD3); end
        total++; if (LU_READY !== 1'b1) begin bad++; $display("[TB] FAIL full_ready3 got=%0h want=1", LU_READY); end
        tick();
        LU_VALID = 1'b0;
        total++; if (RF_A3 !== 5'd11 || RF_WD3 !== 32'hB0) begin bad++; $display("[TB] FAIL full_pop2 got=%0h/%0h want=b/b0", RF_A3, RF_WD3); end
        total++; if (PEND_MASK !== 32'h1800) begin bad++; $display("[TB] FAIL full_pend2 got=%0h want=1800", PEND_MASK); end
        tick();
        total++; if (RF_WE !== 1'b1 || RF_A3 !== 5'd12 || RF_WD3 !== 32'hC0) begin bad++; $display("[TB] FAIL full_pop3 got=%0h/%0h/%0h want=1/c/c0", RF_WE, RF_A3, RF_WD3); end
        tick();
        total++; if (RF_WE !== 1'b0) begin bad++; $display("[TB] FAIL full_we_end got=%0h want=0", RF_WE); end
        total++; if (DEFER_CNT !== 16'd4) begin bad++; $display("[TB] FAIL full_defer got=%0d want=4", DEFER_CNT); end
    endtask

    task automatic test_waw_kill();
        LU_VALID = 1'b1; LU_ADDR = 5'd9; LU_DATA = 32'hAA;
        tick();
        LU_VALID = 1'b0;
        WB_VALID = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'hBB;
        tick();
        WB_VALID = 1'b0;
        total++; if (RF_WD3 !== 32'hBB || PEND_MASK !== 32'h200) begin bad++; $display("[TB] FAIL waw_wb got=%0h/%0h want=bb/200", RF_WD3, PEND_MASK); end
        tick();
        total++; if (RF_WE !== 1'b0) begin bad++; $display("[TB] FAIL waw_dead_we got=%0h want=0", RF_WE); end
        total++; if (RF_A3 !== 5'd9 || RF_WD3 !== 32'hBB) begin bad++; $display("[TB] FAIL waw_final got=%0h/%0h want=9/bb", RF_A3, RF_WD3); end
        total++; if (PEND_MASK !== 32'h0) begin bad++; $display("[TB] FAIL waw_pend got=%0h want=0", PEND_MASK); end
        total++; if (DEFER_CNT !== 16'd5) begin bad++; $display("[TB] FAIL waw_defer got=%0d want=5", DEFER_CNT); end
        LU_VALID = 1'b1; LU_ADDR = 5'd9; LU_DATA = 32'hCC;
        WB_VALID = 1'b1; WB_ADDR = 5'd9; WB_DATA = 32'hDD;
        tick();
        drive_idle();
        total++; if (PEND_MASK !== 32'h200 || RF_WD3 !== 32'hDD) begin bad++; $display("[TB] FAIL waw_same got=%0h/%0h want=200/dd", PEND_MASK, RF_WD3); end
        tick();
        total++; if (RF_WE !== 1'b0 || RF_WD3 !== 32'hDD) begin bad++; $display("[TB] FAIL waw_same_pop got=%0h/%0h want=0/dd", RF_WE, RF_WD3); end
        total++; if (DEFER_CNT !== 16'd5) begin bad++; $display("[TB] FAIL waw_defer2 got=%0d want=5", DEFER_CNT); end
    endtask

    task automatic test_reg0();
        LU_VALID = 1'b1; LU_ADDR = 5'd4; LU_DATA = 32'h44;
        tick();
        LU_VALID = 1'b0;
        WB_VALID = 1'b1; WB_ADDR = 5'd0; WB_DATA = 32'hFF;
        tick();
        WB_VALID = 1'b0;
        total++; if (RF_WE !== 1'b1 || RF_A3 !== 5'd4 || RF_WD3 !== 32'h44) begin bad++; $display("[TB] FAIL r0_drain got=%0h/%0h/%0h want=1/4/44", RF_WE, RF_A3, RF_WD3); end
        LU_VALID = 1'b1; LU_ADDR = 5'd0; LU_DATA = 32'h99;
        tick();
        LU_VALID = 1'b0;
        total++; if (RF_WE !== 1'b0 || PEND_MASK !== 32'h0) begin bad++; $display("[TB] FAIL r0_lu got=%0h/%0h want=0/0", RF_WE, PEND_MASK); end
        tick();
        total++; if (RF_WE !== 1'b0 || RF_WD3 !== 32'h44) begin bad++; $display("[TB] FAIL r0_never got=%0h/%0h want=0/44", RF_WE, RF_WD3); end
        total++; if (DEFER_CNT !== 16'd5) begin bad++; $display("[TB] FAIL r0_defer got=%0d want=5", DEFER_CNT); end
    endtask

    task automatic test_reset_mid();
        WB_VALID = 1'b1; WB_ADDR = 5'd2; WB_DATA = 32'h22;
        LU_VALID = 1'b1; LU_ADDR = 5'd13; LU_DATA = 32'hD0;
        tick();
        LU_ADDR = 5'd14; LU_DATA = 32'hE0;
        tick();
        drive_idle();
        total++; if (PEND_MASK !== 32'h6004) begin bad++; $display("[TB] FAIL mid_pend got=%0h want=6004", PEND_MASK); end
        #2;
        RESETN = 1'b0;
        #1;
        total++; if (RF_WE !== 1'b0 || RF_A3 !== 5'd0 || RF_WD3 !== 32'd0) begin bad++; $display("[TB] FAIL mid_out got=%0h/%0h/%0h want=0/0/0", RF_WE, RF_A3, RF_WD3); end
        total++; if (PEND_MASK !== 32'd0 || DEFER_CNT !== 16'd0) begin bad++; $display("[TB] FAIL mid_state got=%0h/%0h want=0/0", PEND_MASK, DEFER_CNT); end
        total++; if (LU_READY !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready got=%0h want=0", LU_READY); end
        tick();
        RESETN = 1'b1;
        #1;
        total++; if (LU_READY !== 1'b1) begin bad++; $display("[TB] FAIL mid_rel_ready got=%0h want=1", LU_READY); end
        LU_VALID = 1'b1; LU_ADDR = 5'd15; LU_DATA = 32'hF0;
        tick();
        LU_VALID = 1'b0;
        total++; if (PEND_MASK !== 32'h8000 || RF_WE !== 1'b0) begin bad++; $display("[TB] FAIL mid_empty got=%0h/%0h want=8000/0", PEND_MASK, RF_WE); end
        tick();
        total++; if (RF_WE !== 1'b1 || RF_A3 !== 5'd15 || RF_WD3 !== 32'hF0) begin bad++; $display("[TB] FAIL mid_pop got=%0h/%0h/%0h want=1/f/f0", RF_WE, RF_A3, RF_WD3); end
    endtask

    initial begin
        test_reset();
        test_wb_only();
        test_contention();
        test_full();
        test_waw_kill();
        test_reg0();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_write_sched.md
# rf_write_sched

Write-port scheduler for the 32×32 register file in the pipelined CPU. The register file has a single write port (A3/WD3/RegWriteW), written on the falling edge of CLOCK. This block shares that port between two writers: the in-order writeback stage and the long-latency unit (multiply/divide/load-miss return).
- Writeback always wins the port.
- Long-latency results wait in a small FIFO and drain in free cycles.
- A pending-register mask tells decode which registers are not yet safe to read.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- DEPTH, 2, long-latency FIFO entries (power of 2, ≥2)

Ports:
- CLOCK  in  1  system clock; all state updates on the rising edge
- RESETN  in  1  asynchronous, active-low reset
- WB_VALID  in  1  writeback stage has a result this cycle; cannot be stalled
- WB_ADDR  in  ADDR_W  writeback destination register
- WB_DATA  in  DATA_W  writeback data
- LU_VALID  in  1  long-latency unit offers a result
- LU_READY  out  1  scheduler can accept a result; LU transfer = LU_VALID && LU_READY at the rising edge
- LU_ADDR  in  ADDR_W  long-latency destination register
- LU_DATA  in  DATA_W  long-latency data
- RF_WE  out  1  drives RegWriteW; registered
- RF_A3  out  ADDR_W  drives A3; registered
- RF_WD3  out  DATA_W  drives WD3; registered
- PEND_MASK  out  32  bit r = 1 means a write to register r is queued or in flight
- DEFER_CNT  out  16  saturating count of cycles a live FIFO head was blocked by writeback

## Operation
- Source selection at each rising edge, in priority order:
  - Writeback, if WB_VALID && WB_ADDR≠0.
  - Otherwise the FIFO head, if the FIFO is non-empty.
  - Otherwise none.
- Output register:
  - Winner loads RF_A3/RF_WD3 and sets RF_WE=1.
  - No winner gives RF_WE=0; RF_A3 and RF_WD3 hold their values.
- Register 0 is never written. WB with address 0 is ignored and counts as "no WB", so the FIFO may drain that cycle. An LU transfer with address 0 is accepted but not enqueued.
- FIFO:
  - DEPTH entries of {live, addr, data}, in order.
  - LU_READY = RESETN && (count < DEPTH). It does not depend on a same-cycle pop, so there is no combinational path from LU_VALID to LU_READY.
  - The head pops whenever writeback does not take the port.
  - A popped dead entry produces RF_WE=0.
- WAW kill: when writeback wins with address r, every FIFO entry with addr r has its live bit cleared at the same edge. An LU entry with address r enqueued at that same edge is also marked dead. Writeback is always the younger write.
- PEND_MASK:
  - Includes the one-hot decode of every live FIFO entry's addr.
  - Includes onehot(RF_A3) when RF_WE=1.
  - Is combinational from registered state; bit 0 is always 0.
- DEFER_CNT: increments when WB wins while the FIFO head is live. Saturates at 0xFFFF.

## Timing
- Reset (async assert, sync release):
  - RF_WE=0, RF_A3=0, RF_WD3=0.
  - FIFO empty, DEFER_CNT=0, PEND_MASK=0.
  - LU_READY=0 while RESETN is low and 1 on the first cycle after release.
- Reset mid-operation discards all queued LU results. The LU must reissue them.
- WB latency: accepted at edge k, RF_WE high in cycle k..k+1, register file updated at the falling edge inside that cycle. Decode reading after that falling edge sees the new value.
- LU latency, best case: transfer at edge k, pop at edge k+1, register file written at the falling edge of cycle k+1..k+2.
- Simultaneous push and pop: count is unchanged.
- Push when full: cannot occur, because LU_READY=0.
- Pointers wrap modulo DEPTH.
- Continuous WB_VALID starves the FIFO indefinitely. Decode's PEND_MASK stall guarantees writeback bubbles, which lets the FIFO drain.

## Structure
- Package rf_sched_pkg:
  - DATA_W/ADDR_W defaults.
  - Entry struct {live, addr, data}.
  - Function onehot32(addr).
- Sub-module rf_sched_fifo:
  - Holds entry storage, pointers and count.
  - Performs the kill-by-address compare across all entries.
  - Exposes head, full, empty and the per-entry live/addr vector for PEND_MASK.
- The top level holds source selection, the output register, the mask OR-tree and DEFER_CNT.

## Test plan
- Reset: assert RESETN=0 mid-stream with 2 queued entries. Required: all outputs 0 immediately, LU_READY=0. After release, LU_READY=1, FIFO empty, PEND_MASK=0.
- WB only: WB_VALID=1, addr 5, data 0xDEADBEEF at edge k. Required: RF_WE=1, RF_A3=5, RF_WD3=0xDEADBEEF in the following cycle; PEND_MASK=0x20 during that cycle, then 0.
- Contention:
  - Stimulus: LU writes r7=0x11 at edge k; WB writes r3 at edges k+1 and k+2.
  - Required: r7 is written in the cycle after edge k+3, and DEFER_CNT=2.
- Full FIFO: two LU pushes with no drain (WB busy). Required: LU_READY=0, a third LU_VALID is held off, and the result is accepted one cycle after the first pop.
- WAW kill: FIFO holds r9=0xAA, then WB writes r9=0xBB. Required: the FIFO pop produces RF_WE=0, and r9 ends as 0xBB.
- Register 0: WB addr 0 with the FIFO non-empty. Required: the FIFO drains that cycle. LU addr 0 is accepted, never written, and never shows in PEND_MASK.
